// File: rtl/hex_word_sender.sv
// Prints a 4*NIBBLES-bit word as ASCII hex (MS nibble first) on a byte valid/ready stream.
// Optional trailing CR/LF when HEXDUMP_CRLF_EN is defined; first char one cycle after start; holds output while tx_ready=0.
module hex_word_sender #(
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           nib_out,
  input  logic [3:0]           asc_hi,
  input  logic [3:0]           asc_lo,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    sr;
  logic [CW-1:0]   cnt;
  logic            hs;
  logic            fin;

  assign hs = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    busy      = 1'b0;
    tx_valid  = 1'b0;
    nib_out   = 4'h0;
    tx_data   = 8'h00;
    case (state)
      IDLE: begin
        if (start) state_nxt = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        nib_out  = sr[W-1 -: 4];
        tx_data  = {asc_hi, asc_lo};
        if (tx_ready && cnt == '0) begin
`ifdef HEXDUMP_CRLF_EN
          state_nxt = CR;
`else
          state_nxt = IDLE;
          fin       = 1'b1;
`endif
        end
      end
      CR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) state_nxt = LF;
      end
      LF: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) begin
          state_nxt = IDLE;
          fin       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register always presents the next digit in its top nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (state == IDLE && start) begin
        sr  <= data_in;
        cnt <= CW'(NIBBLES - 1);
      end else if (state == SEND && hs) begin
        sr  <= sr << 4;
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hex_word_sender.sv
// Bench for hex_word_sender: table vectors, hand-written corner sequences and random words vs a reference model.
module tb_hex_word_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] data_in;
  logic        busy, done, tx_valid, tx_ready;
  logic [3:0]  nib_out, asc_hi, asc_lo;
  logic [7:0]  tx_data;

  logic        s_start, s_busy, s_done, s_txv, s_rdy;
  logic [7:0]  s_data, s_txd;
  logic [3:0]  s_nib, s_hi, s_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Nibble-to-ASCII converter that sits outside the design.
  assign asc_hi = (nib_out < 4'd10) ? 4'h3 : 4'h4;
  assign asc_lo = (nib_out < 4'd10) ? nib_out : nib_out - 4'd9;
  assign s_hi   = (s_nib < 4'd10) ? 4'h3 : 4'h4;
  assign s_lo   = (s_nib < 4'd10) ? s_nib : s_nib - 4'd9;

  hex_word_sender #(.NIBBLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .nib_out(nib_out), .asc_hi(asc_hi), .asc_lo(asc_lo),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  hex_word_sender #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .data_in(s_data),
    .busy(s_busy), .done(s_done), .nib_out(s_nib), .asc_hi(s_hi), .asc_lo(s_lo),
    .tx_data(s_txd), .tx_valid(s_txv), .tx_ready(s_rdy)
  );

`ifdef HEXDUMP_CRLF_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: hex string of a 32-bit word, packed first char in the top byte.
  function automatic logic [63:0] hex_string(input logic [31:0] w);
    logic [63:0] s;
    int d;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      d = (w / (32'h1 << (4 * (7 - i)))) % 16;
      s[63 - 8*i -: 8] = (d < 10) ? 8'(48 + d) : 8'(55 + d);
    end
    return s;
  endfunction

  // mode 0: ready held; 1: stray start on char 3; 2: 3-cycle stall on char 2; 3: random ready.
  // Entered and left on a negedge; on exit the current cycle is the expected done cycle.
  task automatic run_word(input logic [31:0] d, input logic [63:0] chars, input int mode);
    int idx, cyc, stall;
    logic [7:0] ec;
    logic [3:0] en;
    chk("busy_before_start", busy, 0);
    start = 1'b1;
    data_in = d;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0; stall = 0;
    while (idx < 8 + EXTRA && cyc < 400) begin
      if (idx < 8) begin
        ec = chars[63 - 8*idx -: 8];
        en = 4'((d >> (4 * (7 - idx))) & 32'hF);
      end else begin
        ec = (idx == 8) ? 8'h0D : 8'h0A;
        en = 4'h0;
      end
      chk("tx_valid", tx_valid, 1);
      chk("tx_data", tx_data, ec);
      chk("nib_out", nib_out, en);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      start = 1'b0;
      case (mode)
        1: begin
          tx_ready = 1'b1;
          if (idx == 2 && stall == 0) begin
            start = 1'b1; data_in = 32'hFFFF_FFFF; stall = 1;
          end
        end
        2: begin
          tx_ready = !(idx == 1 && stall < 3);
          if (!tx_ready) stall++;
        end
        3: tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = 1'b1;
      endcase
      @(negedge clk);
      if (tx_ready) idx++;
      cyc++;
    end
    start = 1'b0;
    chk("char_budget", (idx == 8 + EXTRA) ? 1 : 0, 1);
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", tx_valid, 0);
  endtask

  typedef struct {
    logic [31:0] d;
    logic [63:0] chars;
    int          mode;
  } vec_t;

  vec_t tab[4];

  initial begin
    tab[0] = '{32'h1234_ABCF, 64'h3132_3334_4142_4346, 0};
    tab[1] = '{32'h0000_0009, 64'h3030_3030_3030_3039, 2};
    tab[2] = '{32'hDEAD_BEEF, 64'h4445_4144_4245_4546, 1};
    tab[3] = '{32'h0F0F_0F0F, 64'h3046_3046_3046_3046, 0};

    rst_n = 1'b0; start = 1'b0; data_in = '0; tx_ready = 1'b0;
    s_start = 1'b0; s_data = '0; s_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_nib", nib_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each word starts in the done cycle of the previous one.
    for (int i = 0; i < 4; i++) run_word(tab[i].d, tab[i].chars, tab[i].mode);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    repeat (3) begin
      chk("idle_valid", tx_valid, 0);
      @(negedge clk);
    end

    // Reset during the fifth character.
    start = 1'b1; data_in = 32'h8765_4321;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_char5", tx_data, 8'h34);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", tx_valid, 0);
      chk("post_rst_busy", busy, 0);
    end

    for (int i = 0; i < 20; i++) begin
      logic [31:0] w;
      w = $urandom;
      run_word(w, hex_string(w), 3);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Two-digit instance.
    begin
      logic [7:0] exp2 [4];
      int cyc;
      exp2[0] = 8'h41; exp2[1] = 8'h35; exp2[2] = 8'h0D; exp2[3] = 8'h0A;
      s_start = 1'b1; s_data = 8'hA5;
      @(negedge clk);
      s_start = 1'b0;
      for (int i = 0; i < 2 + EXTRA; i++) begin
        chk("n2_valid", s_txv, 1);
        chk("n2_data", s_txd, exp2[i]);
        chk("n2_done_low", s_done, 0);
        @(negedge clk);
      end
      chk("n2_done", s_done, 1);
      chk("n2_valid_after", s_txv, 0);
      cyc = 0;
      @(negedge clk);
      chk("n2_done_cleared", s_done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
